// File: rtl/dlf_biquad_mac.sv
// Second-order IIR loop filter core for the ADPLL: one shared multiplier walks the
// four biquad terms, then a rounding/saturating update stage writes the control word.
module dlf_biquad_mac #(
   parameter int IN_W   = 16,
   parameter int COEF_W = 18,
   parameter int FRAC   = 16,
   parameter int OUT_W  = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     sys_clk,
   input  logic                     por_rstn,
   input  logic                     dlf_en,
   input  logic signed [IN_W-1:0]   dlf_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [COEF_W-1:0] dlf_a2,
   input  logic signed [COEF_W-1:0] dlf_a3,
   input  logic signed [COEF_W-1:0] dlf_b1,
   input  logic signed [COEF_W-1:0] dlf_b2,
   input  logic                     hold,
   input  logic                     load_en,
   input  logic signed [OUT_W-1:0]  load_val,
   input  logic                     clr_sat,
   output logic signed [OUT_W-1:0]  dlf_out,
   output logic                     out_valid,
   output logic                     sat_flag,
   output logic                     busy,
   output logic [2:0]               dbg_state
);

   // Handshake: a sample moves on the rising edge where in_valid & in_ready are both
   // high; in_ready is combinational and is only asserted in IDLE with the filter
   // enabled and no preload pending, so load_en always wins over a sample.

   localparam int D_W = (IN_W > OUT_W) ? IN_W : OUT_W;
   localparam int P_W = COEF_W + D_W;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'd1 << (FRAC - 1));
   localparam logic signed [ACC_W-1:0] OUT_MAX  = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN  = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MAC0 = 3'd1,
      MAC1 = 3'd2,
      MAC2 = 3'd3,
      MAC3 = 3'd4,
      UPD  = 3'd5
   } state_t;

   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic signed [IN_W-1:0]    x_cur;
   logic signed [IN_W-1:0]    x1;
   logic signed [OUT_W-1:0]   y1;
   logic signed [OUT_W-1:0]   y2;
   logic signed [COEF_W-1:0]  sh_a2;
   logic signed [COEF_W-1:0]  sh_a3;
   logic signed [COEF_W-1:0]  sh_b1;
   logic signed [COEF_W-1:0]  sh_b2;

   logic signed [COEF_W-1:0]  mult_a;
   logic signed [D_W-1:0]     mult_b;
   logic signed [P_W-1:0]     prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic                      term_sub;
   logic signed [ACC_W-1:0]   acc_rnd;
   logic signed [ACC_W-1:0]   acc_shr;
   logic signed [OUT_W-1:0]   y_new;
   logic                      clamp;

   // Shared multiplier: operands come from the shadow coefficients and history,
   // the feedback terms are subtracted rather than negating the coefficient.
   always_comb begin
      mult_a   = '0;
      mult_b   = '0;
      term_sub = 1'b0;
      case (state)
         MAC0: begin
            mult_a = sh_b1;
            mult_b = D_W'(x_cur);
         end
         MAC1: begin
            mult_a = sh_b2;
            mult_b = D_W'(x1);
         end
         MAC2: begin
            mult_a   = sh_a2;
            mult_b   = D_W'(y1);
            term_sub = 1'b1;
         end
         MAC3: begin
            mult_a   = sh_a3;
            mult_b   = D_W'(y2);
            term_sub = 1'b1;
         end
         default: begin
            mult_a = '0;
            mult_b = '0;
         end
      endcase
   end

   assign prod     = mult_a * mult_b;
   assign prod_ext = ACC_W'(prod);

   always_comb begin
      acc_rnd = acc + RND_HALF;
      acc_shr = acc_rnd >>> FRAC;
      clamp   = 1'b0;
      y_new   = acc_shr[OUT_W-1:0];
      if (acc_shr > OUT_MAX) begin
         clamp = 1'b1;
         y_new = OUT_MAX[OUT_W-1:0];
      end else if (acc_shr < OUT_MIN) begin
         clamp = 1'b1;
         y_new = OUT_MIN[OUT_W-1:0];
      end
   end

   assign in_ready  = (state == IDLE) & dlf_en & ~load_en;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge sys_clk or negedge por_rstn) begin
      if (!por_rstn) begin
         state     <= IDLE;
         acc       <= '0;
         x_cur     <= '0;
         x1        <= '0;
         y1        <= '0;
         y2        <= '0;
         sh_a2     <= '0;
         sh_a3     <= '0;
         sh_b1     <= '0;
         sh_b2     <= '0;
         dlf_out   <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (!dlf_en) begin
            // Disable drops any sample in flight; the output word and sticky flag survive.
            state <= IDLE;
            acc   <= '0;
            x1    <= '0;
            y1    <= '0;
            y2    <= '0;
         end else begin
            sat_flag <= (state == UPD && !hold && clamp) | (sat_flag & ~clr_sat);
            case (state)
               IDLE: begin
                  if (load_en) begin
                     dlf_out <= load_val;
                     y1      <= load_val;
                     y2      <= load_val;
                     x1      <= '0;
                  end else if (in_valid) begin
                     x_cur <= dlf_in;
                     sh_a2 <= dlf_a2;
                     sh_a3 <= dlf_a3;
                     sh_b1 <= dlf_b1;
                     sh_b2 <= dlf_b2;
                     acc   <= '0;
                     state <= MAC0;
                  end
               end
               MAC0: begin
                  acc   <= acc + prod_ext;
                  state <= MAC1;
               end
               MAC1: begin
                  acc   <= acc + prod_ext;
                  state <= MAC2;
               end
               MAC2: begin
                  acc   <= term_sub ? acc - prod_ext : acc + prod_ext;
                  state <= MAC3;
               end
               MAC3: begin
                  acc   <= term_sub ? acc - prod_ext : acc + prod_ext;
                  state <= UPD;
               end
               UPD: begin
                  out_valid <= 1'b1;
                  if (!hold) begin
                     dlf_out <= y_new;
                     y2      <= y1;
                     y1      <= y_new;
                     x1      <= x_cur;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dlf_biquad_mac.sv
// Directed bench for dlf_biquad_mac: an arithmetic reference of the biquad feeds an
// expected queue checked on every out_valid, plus literal values per scenario.
module tb_dlf_biquad_mac;

   logic               sys_clk;
   logic               por_rstn;
   logic               dlf_en;
   logic signed [15:0] dlf_in;
   logic               in_valid;
   logic               in_ready;
   logic signed [17:0] dlf_a2;
   logic signed [17:0] dlf_a3;
   logic signed [17:0] dlf_b1;
   logic signed [17:0] dlf_b2;
   logic               hold;
   logic               load_en;
   logic signed [15:0] load_val;
   logic               clr_sat;
   logic signed [15:0] dlf_out;
   logic               out_valid;
   logic               sat_flag;
   logic               busy;
   logic [2:0]         dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] exp_q[$];
   longint mx1, my1, my2, mdout;
   bit     msat;

   dlf_biquad_mac dut (
      .sys_clk   (sys_clk),
      .por_rstn  (por_rstn),
      .dlf_en    (dlf_en),
      .dlf_in    (dlf_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dlf_a2    (dlf_a2),
      .dlf_a3    (dlf_a3),
      .dlf_b1    (dlf_b1),
      .dlf_b2    (dlf_b2),
      .hold      (hold),
      .load_en   (load_en),
      .load_val  (load_val),
      .clr_sat   (clr_sat),
      .dlf_out   (dlf_out),
      .out_valid (out_valid),
      .sat_flag  (sat_flag),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference model: y = sat(floor((b1*x + b2*x1 - a2*y1 - a3*y2 + 2^15) / 2^16))
   task automatic model_step(input longint x);
      longint acc_m, r;
      bit     sat_m;
      acc_m = longint'(dlf_b1) * x + longint'(dlf_b2) * mx1
            - longint'(dlf_a2) * my1 - longint'(dlf_a3) * my2;
      r     = (acc_m + 64'sd32768) >>> 16;
      sat_m = 1'b0;
      if (r > 32767) begin r = 32767; sat_m = 1'b1; end
      if (r < -32768) begin r = -32768; sat_m = 1'b1; end
      if (!hold) begin
         mdout = r;
         my2   = my1;
         my1   = r;
         mx1   = x;
         if (sat_m) msat = 1'b1;
      end
      exp_q.push_back(16'(mdout));
   endtask

   task automatic model_clear();
      mx1 = 0;
      my1 = 0;
      my2 = 0;
   endtask

   // scoreboard: every out_valid must match the next queued expectation
   always @(negedge sys_clk) begin
      logic [15:0] exp_v;
      if (por_rstn && out_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream_unexpected_strobe: got dlf_out=%0d expected no out_valid", dlf_out);
         end else begin
            exp_v = exp_q.pop_front();
            check("stream_dlf_out", longint'(dlf_out), longint'($signed(exp_v)));
         end
      end
   end

   // driver: present a sample, wait (bounded) for acceptance, drop in_valid after it
   task automatic send(input int x, input bit expect_out);
      int n;
      dlf_in   = 16'(x);
      in_valid = 1'b1;
      n        = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge sys_clk);
         #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      else if (expect_out) model_step(longint'(x));
      @(negedge sys_clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input int exp);
      int n;
      n = 0;
      while (n < 20) begin
         @(negedge sys_clk);
         if (out_valid) break;
         n++;
      end
      if (!out_valid) check({name, "_timeout"}, 0, 1);
      else check(name, longint'(dlf_out), longint'(exp));
   endtask

   initial begin
      int pulses;
      por_rstn = 1'b0;
      dlf_en   = 1'b0;
      dlf_in   = '0;
      in_valid = 1'b0;
      dlf_a2   = '0;
      dlf_a3   = '0;
      dlf_b1   = '0;
      dlf_b2   = '0;
      hold     = 1'b0;
      load_en  = 1'b0;
      load_val = '0;
      clr_sat  = 1'b0;
      model_clear();
      mdout = 0;
      msat  = 1'b0;

      // reset and idle
      #3;
      check("rst_dlf_out", longint'(dlf_out), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_sat_flag", longint'(sat_flag), 0);
      check("rst_busy", longint'(busy), 0);
      repeat (2) @(negedge sys_clk);
      por_rstn = 1'b1;
      in_valid = 1'b1;
      dlf_in   = 16'sd7;
      #1;
      check("disabled_in_ready", longint'(in_ready), 0);
      repeat (4) @(negedge sys_clk);
      check("disabled_busy", longint'(busy), 0);
      in_valid = 1'b0;
      dlf_en   = 1'b1;

      // pass-through and latency
      dlf_b1 = 18'sd65536;
      @(negedge sys_clk);
      dlf_in   = 16'sd100;
      in_valid = 1'b1;
      #1;
      check("pass_in_ready_idle", longint'(in_ready), 1);
      model_step(100);
      @(negedge sys_clk);
      in_valid = 1'b0;
      check("pass_busy_e0", longint'(busy), 1);
      check("pass_in_ready_e0", longint'(in_ready), 0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge sys_clk);
         if (k < 5) begin
            check("pass_no_strobe_early", longint'(out_valid), 0);
            check("pass_in_ready_busy", longint'(in_ready), 0);
         end else begin
            check("pass_strobe_e5", longint'(out_valid), 1);
            check("pass_dlf_out", longint'(dlf_out), 100);
            check("pass_in_ready_back", longint'(in_ready), 1);
         end
      end
      @(negedge sys_clk);
      check("pass_strobe_single", longint'(out_valid), 0);

      // integrator from cleared history; third sample sees a coef change at E2
      dlf_en = 1'b0;
      @(negedge sys_clk);
      dlf_en = 1'b1;
      model_clear();
      dlf_a2 = -18'sd65536;
      send(10, 1'b1);
      wait_out("integ_10", 10);
      send(10, 1'b1);
      wait_out("integ_20", 20);
      send(10, 1'b1);
      @(negedge sys_clk);
      dlf_a2 = 18'sd12345;
      dlf_b1 = '0;
      wait_out("integ_30_coef_change", 30);
      dlf_a2 = -18'sd65536;
      dlf_b1 = 18'sd65536;

      // saturation and sticky flag
      send(32767, 1'b1);
      wait_out("sat_pos_1", 32767);
      check("sat_flag_set", longint'(sat_flag), 1);
      send(32767, 1'b1);
      wait_out("sat_pos_2", 32767);
      @(negedge sys_clk);
      clr_sat = 1'b1;
      @(negedge sys_clk);
      clr_sat = 1'b0;
      msat    = 1'b0;
      check("sat_flag_cleared", longint'(sat_flag), 0);
      send(-32768, 1'b1);
      wait_out("sat_neg_1", -1);
      send(-32768, 1'b1);
      wait_out("sat_neg_2", -32768);
      check("sat_flag_model", longint'(sat_flag), longint'(msat));

      // rounding with b1 = 0.5
      dlf_b1 = 18'sd32768;
      dlf_a2 = '0;
      send(3, 1'b1);
      wait_out("rnd_p3", 2);
      send(-3, 1'b1);
      wait_out("rnd_m3", -1);
      send(1, 1'b1);
      wait_out("rnd_p1", 1);

      // preload (beats a simultaneous sample), hold, disable mid-flight
      dlf_b1 = 18'sd65536;
      dlf_a2 = -18'sd65536;
      @(negedge sys_clk);
      load_en  = 1'b1;
      load_val = 16'sd500;
      in_valid = 1'b1;
      dlf_in   = 16'sd77;
      #1;
      check("load_blocks_ready", longint'(in_ready), 0);
      mdout = 500;
      my1   = 500;
      my2   = 500;
      mx1   = 0;
      @(negedge sys_clk);
      load_en  = 1'b0;
      in_valid = 1'b0;
      check("load_dlf_out", longint'(dlf_out), 500);
      check("load_not_busy", longint'(busy), 0);
      send(5, 1'b1);
      wait_out("load_then_5", 505);
      hold = 1'b1;
      send(5, 1'b1);
      wait_out("hold_keeps", 505);
      hold = 1'b0;
      send(5, 1'b0);
      repeat (2) @(negedge sys_clk);
      dlf_en = 1'b0;
      @(negedge sys_clk);
      check("drop_idle", longint'(busy), 0);
      check("drop_out_holds", longint'(dlf_out), 505);
      dlf_en = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(negedge sys_clk);
         if (out_valid) pulses++;
      end
      check("drop_no_strobe", longint'(pulses), 0);
      model_clear();
      send(5, 1'b1);
      wait_out("after_drop_5", 5);

      repeat (3) @(negedge sys_clk);
      check("queue_drained", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
